// File: rtl/qam_symbol_sequencer.sv
// Purpose: maps 16-QAM symbols to Gray-coded I/Q levels and gates sine_gen stepping per whole carrier periods.
// Latency: first step and levels one cycle after accept; back-to-back symbols leave no bubble in step.
// Backpressure: sym_ready only in IDLE or on the last cycle of a symbol, and only when en=1.
// Optional feature macro: QAM_SEQ_GAP_FILL_EN (underrun inserts a zero-level fill symbol instead of halting).
module qam_symbol_sequencer #(
  parameter int ADDR_WIDTH     = 12,
  parameter int CYCLES_PER_SYM = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] sym_data,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       step,
  output logic [2:0] i_level,
  output logic [2:0] q_level,
  output logic       sym_start,
  output logic       busy,
  output logic       underrun
);

  localparam int CW = (CYCLES_PER_SYM > 1) ? $clog2(CYCLES_PER_SYM) : 1;
  localparam logic [ADDR_WIDTH-1:0] PHASE_LAST = '1;
  localparam logic [CW-1:0]         CYC_LAST   = CW'(CYCLES_PER_SYM - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] phase_cnt_q, phase_cnt_d;
  logic [CW-1:0]         cyc_cnt_q, cyc_cnt_d;
  logic [2:0]            i_level_q, i_level_d;
  logic [2:0]            q_level_q, q_level_d;
  logic                  sym_start_q, sym_start_d;
  logic                  underrun_q, underrun_d;
  logic                  boundary;
  logic                  accept;

  // Gray-coded amplitude: 00->-3, 01->-1, 11->+1, 10->+3
  function automatic logic [2:0] gray_level(input logic [1:0] f);
    logic [2:0] lv;
    unique case (f)
      2'b00:   lv = 3'b101;
      2'b01:   lv = 3'b111;
      2'b11:   lv = 3'b001;
      default: lv = 3'b011;
    endcase
    return lv;
  endfunction

  // Boundary is the final step cycle of a symbol; it is the only RUN cycle that may accept.
  always_comb begin
    boundary  = (state_q == RUN) && (phase_cnt_q == PHASE_LAST) && (cyc_cnt_q == CYC_LAST);
    sym_ready = rst_n && en && ((state_q == IDLE) || boundary);
    accept    = sym_ready && sym_valid;
  end

  // Next-state, counter and level logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    i_level_d   = i_level_q;
    q_level_d   = q_level_q;
    sym_start_d = 1'b0;
    underrun_d  = 1'b0;

    if (state_q == RUN) begin
      phase_cnt_d = phase_cnt_q + 1'b1;
      if (phase_cnt_q == PHASE_LAST) begin
        cyc_cnt_d = cyc_cnt_q + 1'b1;
      end
    end

    if (accept) begin
      state_d     = RUN;
      phase_cnt_d = '0;
      cyc_cnt_d   = '0;
      i_level_d   = gray_level(sym_data[3:2]);
      q_level_d   = gray_level(sym_data[1:0]);
      sym_start_d = 1'b1;
    end else if (boundary) begin
      // Counters restart so a halted carrier always rests at phase 0.
      phase_cnt_d = '0;
      cyc_cnt_d   = '0;
      i_level_d   = '0;
      q_level_d   = '0;
      if (!en) begin
        state_d = IDLE;
      end else begin
        underrun_d = 1'b1;
`ifdef QAM_SEQ_GAP_FILL_EN
        state_d    = RUN;
`else
        state_d    = IDLE;
`endif
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      cyc_cnt_q   <= '0;
      i_level_q   <= '0;
      q_level_q   <= '0;
      sym_start_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      i_level_q   <= i_level_d;
      q_level_q   <= q_level_d;
      sym_start_q <= sym_start_d;
      underrun_q  <= underrun_d;
    end
  end

  // Step and busy are decoded straight from the state register.
  always_comb begin
    step      = (state_q == RUN);
    busy      = (state_q == RUN);
    i_level   = i_level_q;
    q_level   = q_level_q;
    sym_start = sym_start_q;
    underrun  = underrun_q;
  end

endmodule
